addr_read_stage: RTL and testbench
==================================

# addr_read_stage

Memory read stage that sits directly downstream of the 2D strided address generator. It accepts the generated `addr` stream over a valid/ready handshake and issues one synchronous SRAM read per accepted address. Each read returns after a fixed one-cycle latency and lands in a small output FIFO, which delivers the data, in order, to the consumer under valid/ready backpressure. Credit-based admission guarantees the FIFO never overflows, so no returning read is ever dropped.

## Interface
- `DATA_W`, 32, width of SRAM read data and output data
- `MEM_AW`, 10, SRAM address width; the low `MEM_AW` bits of `addr` index the SRAM
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, minimum 2

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `addr_valid`  in  1  upstream address valid
- `addr_ready`  out  1  stage can accept an address this cycle
- `addr`  in  32  byte-agnostic word address from the address generator
- `mem_en`  out  1  SRAM read enable
- `mem_addr`  out  `MEM_AW`  SRAM read address
- `mem_rdata`  in  `DATA_W`  SRAM read data, valid the cycle after `mem_en`
- `data_valid`  out  1  output FIFO non-empty
- `data_ready`  in  1  consumer accepts head of FIFO
- `data`  out  `DATA_W`  FIFO head
- `addr_oob`  out  1  sticky: some accepted `addr` had nonzero bits `[31:MEM_AW]`
- `beats`  out  32  count of completed output transfers

## Operation
- State:
  - FIFO storage with `count` in 0..`FIFO_DEPTH` and read/write pointers.
  - `inflight` (1 bit): a read was issued in the previous cycle.
  - `addr_oob`.
  - `beats`.
- Admission:
  - `addr_ready = (count + inflight) < FIFO_DEPTH`.
  - This is a function of registers only, with no combinational path from `data_ready` or `addr_valid`.
- Issue:
  - `accept = addr_valid && addr_ready`.
  - `mem_en = accept` (combinational).
  - `mem_addr = addr[MEM_AW-1:0]` (combinational).
  - `inflight <= accept`.
- Return: when `inflight` is 1, `mem_rdata` is written to the FIFO at the write pointer; the write pointer increments modulo `FIFO_DEPTH`.
- Pop:
  - `pop = data_valid && data_ready`.
  - The read pointer increments modulo `FIFO_DEPTH`.
  - `beats` increments by 1 and wraps from 2^32-1 to 0.
- Count update: `count <= count + push - pop`, where `push = inflight`.
  - Simultaneous push and pop leave `count` unchanged.
  - Push into a full FIFO is unreachable by construction; a push at that point is a bench-flagged assertion failure.
- Out-of-range addresses:
  - If `accept` and `addr[31:MEM_AW] != 0`, set `addr_oob`.
  - The read still issues with the truncated address.
  - `addr_oob` clears only on reset.
- Ordering: output order equals acceptance order. No reordering and no drops.
- `data` is undefined when `data_valid` is 0. The bench checks `data` only on `pop`.

## Timing
- Reset (`rst_n` = 0 at a rising edge) forces:
  - `count` = 0, both pointers = 0, `inflight` = 0
  - `addr_oob` = 0, `beats` = 0
- Resulting output values during and after reset:
  - `data_valid` = 0, `addr_ready` = 1.
  - `mem_en` follows `addr_valid`. Upstream holds `addr_valid` low during reset; during reset `mem_en` is don't-care and any accept is discarded.
- Reset mid-operation:
  - A read in flight is discarded; `mem_rdata` is ignored on the cycle after reset.
  - FIFO contents are lost.
- Latency: an address accepted at edge T produces data in the FIFO at edge T+1, so `data_valid` is high in the cycle after edge T+1.
  - Accept to output: 2 cycles.
- Throughput:
  - 1 address per cycle sustained while `data_ready` is held high.
  - With `data_ready` low, at most `FIFO_DEPTH` addresses are accepted before `addr_ready` drops.
  - `addr_ready` drops in the cycle in which `count + inflight` reaches `FIFO_DEPTH`.
- After `data_ready` returns high: the first pop at edge P lowers `count`, so `addr_ready` = 1 in the following cycle.

## Test plan
- Reset then stream addrs 0..7 with `data_ready` = 1 and SRAM preloaded with mem[i] = 0x100+i:
  - `data` = 0x100..0x107 in order.
  - First `data_valid` 2 cycles after first accept.
  - `beats` = 8.
  - No bubbles after the first beat.
- Stall with `data_ready` = 0 and `addr_valid` held at 1:
  - Exactly 4 accepts, then `addr_ready` = 0, `count` = 4, `mem_en` = 0.
  - Raise `data_ready`: 4 pops in order, after which acceptance resumes.
- Random `data_ready` (50%) and random `addr_valid` over 1000 cycles: scoreboard matches, with no overflow and no drop.
- `addr` = 0x0000_0405 with `MEM_AW` = 10:
  - `mem_addr` = 0x005.
  - `addr_oob` = 1 and stays 1 through later in-range accepts until reset.
- Assert `rst_n` = 0 one cycle after an accept with 2 entries queued:
  - Next cycle `data_valid` = 0, `beats` = 0, `addr_oob` = 0.
  - The in-flight `mem_rdata` is never delivered.
- Simultaneous push and pop with `count` = 1 for 10 cycles: `count` stays 1 and data stays in order.

Source files
------------

// File: rtl/addr_read_stage.sv
// addr_read_stage: read stage behind the 2D strided address generator.
// Accepts one address per cycle, issues a synchronous SRAM read for it, and
// lands the returned word (one cycle later) in a small output FIFO that
// drains to the consumer in acceptance order.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   addr_valid/addr_ready address handshake from the generator
//   addr                  32-bit word address; low MEM_AW bits index the SRAM
//   mem_en/mem_addr       SRAM read request (combinational from accept)
//   mem_rdata             SRAM read data, valid the cycle after mem_en
//   data_valid/data_ready output handshake; data is the FIFO head
//   addr_oob              sticky flag: an accepted address had high bits set
//   beats                 count of completed output transfers (wraps)
module addr_read_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_valid,
    output logic              addr_ready,
    input  logic [31:0]       addr,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data,
    output logic              addr_oob,
    output logic [31:0]       beats
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;

    logic accept;
    logic push;
    logic pop;
    logic addr_high;

    // Credit check: stored entries plus the read in flight must leave a free
    // slot, so the return of any read we accept now always has room.
    assign addr_ready = (count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);

    assign accept    = addr_valid && addr_ready;
    assign mem_en    = accept;
    assign mem_addr  = addr[MEM_AW-1:0];
    assign addr_high = addr[ADDR_W-1:MEM_AW] != '0;

    assign push       = inflight;
    assign data_valid = count != '0;
    assign pop        = data_valid && data_ready;
    assign data       = fifo_mem[rd_ptr];

    // Control state: pointers, occupancy, in-flight marker, status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            addr_oob <= 1'b0;
            beats    <= '0;
        end else begin
            inflight <= accept;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                beats  <= beats + 32'd1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (accept && addr_high) begin
                addr_oob <= 1'b1;
            end
        end
    end

    // Storage write; a return arriving on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_addr_read_stage.sv
module tb_addr_read_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MEM_AW = 10;
    localparam int unsigned FD     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              addr_valid;
    logic              addr_ready;
    logic [31:0]       addr;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data;
    logic              addr_oob;
    logic [31:0]       beats;

    addr_read_stage #(.DATA_W(DATA_W), .MEM_AW(MEM_AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .addr_oob(addr_oob), .beats(beats)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency.
    logic [DATA_W-1:0] sram [1 << MEM_AW];
    always @(posedge clk) if (mem_en) mem_rdata <= sram[mem_addr];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: every accepted, not yet delivered address is an
    // outstanding item; it becomes deliverable two cycles after acceptance.
    typedef struct {
        logic [31:0] d;
        int          avail;
    } ent_t;

    ent_t        q[$];
    int          cyc      = 0;
    logic [31:0] m_beats  = 0;
    logic        m_oob    = 0;
    bit          m_active = 0;
    logic [31:0] got_q[$];
    int          pop_cyc[$];
    int          first_a  = -1;
    int          first_v  = -1;

    always @(posedge clk) begin
        bit acc;
        acc = 0;
        if (!rst_n) begin
            q.delete();
            m_beats  = 0;
            m_oob    = 0;
            m_active = 1;
        end else if (m_active) begin
            acc = addr_valid && (q.size() < FD);
            if (q.size() > 0 && q[0].avail <= cyc && data_ready) begin
                void'(q.pop_front());
                m_beats++;
            end
            if (acc) begin
                q.push_back('{sram[addr[MEM_AW-1:0]], cyc + 2});
                if (addr[31:MEM_AW] != 0) m_oob = 1;
            end
        end
        cyc++;
    end

    // Compare process, mid-cycle on the falling edge.
    always @(negedge clk) begin
        bit exp_ready;
        bit exp_valid;
        if (rst_n && m_active) begin
            exp_ready = q.size() < FD;
            exp_valid = q.size() > 0 && q[0].avail <= cyc;
            chk("addr_ready", 32'(addr_ready), 32'(exp_ready));
            chk("mem_en", 32'(mem_en), 32'(addr_valid && exp_ready));
            if (addr_valid && exp_ready)
                chk("mem_addr", 32'(mem_addr), 32'(addr[MEM_AW-1:0]));
            chk("data_valid", 32'(data_valid), 32'(exp_valid));
            chk("beats", beats, m_beats);
            chk("addr_oob", 32'(addr_oob), 32'(m_oob));
            chk("no_overflow", 32'(dut.inflight && (32'(dut.count) == FD)), 32'd0);
            if (exp_valid && data_ready) begin
                chk("data", data, q[0].d);
                got_q.push_back(data);
                pop_cyc.push_back(cyc);
            end
            if (first_a < 0 && mem_en) first_a = cyc;
            if (first_v < 0 && data_valid) first_v = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one address and hold it until the model says it is accepted.
    task automatic send(input logic [31:0] a);
        int guard;
        guard = 0;
        addr       = a;
        addr_valid = 1'b1;
        while (q.size() >= FD && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 32'(guard), 32'd0);
        step();
        addr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        for (int i = 0; i < (1 << MEM_AW); i++)
            sram[i] = (i < 8) ? 32'h100 + 32'(i) : 32'hA500_0000 | 32'(i);

        rst_n      = 1'b0;
        addr_valid = 1'b0;
        addr       = '0;
        data_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_addr_ready", 32'(addr_ready), 32'd1);
        chk("rst_beats", beats, 32'd0);
        chk("rst_oob", 32'(addr_oob), 32'd0);

        // Streaming 0..7 with the consumer always ready.
        data_ready = 1'b1;
        first_a = -1;
        first_v = -1;
        for (int i = 0; i < 8; i++) send(32'(i));
        for (int i = 0; i < 6; i++) step();
        chk("stream_latency", 32'(first_v - first_a), 32'd2);
        chk("stream_beats", beats, 32'd8);
        chk("stream_count", 32'(got_q.size()), 32'd8);
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("stream_data", got_q[i], 32'h100 + 32'(i));
            for (int i = 1; i < 8; i++) chk("stream_no_bubble", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
        end

        // Stall: consumer blocked, address valid held high.
        data_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            bit acc_now;
            acc_now    = q.size() < FD;
            addr       = 32'd16 + 32'(n);
            addr_valid = 1'b1;
            step();
            if (acc_now) n++;
        end
        addr = 32'd16 + 32'(n);
        #1;
        chk("stall_accepts", 32'(n), 32'd4);
        chk("stall_count", 32'(dut.count), 32'd4);
        chk("stall_addr_ready", 32'(addr_ready), 32'd0);
        chk("stall_mem_en", 32'(mem_en), 32'd0);
        addr_valid = 1'b0;
        data_ready = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 8; i++) step();
        chk("drain_count", 32'(got_q.size() - base), 32'd4);
        if (got_q.size() == base + 4)
            for (int i = 0; i < 4; i++) chk("drain_data", got_q[base+i], 32'hA500_0010 + 32'(i));
        chk("resume_ready", 32'(addr_ready), 32'd1);
        send(32'd20);
        step();
        step();

        // Random traffic with in-range addresses.
        for (int i = 0; i < 1000; i++) begin
            addr       = 32'($urandom_range(0, (1 << MEM_AW) - 1));
            addr_valid = 1'($urandom_range(0, 1));
            data_ready = 1'($urandom_range(0, 1));
            step();
        end
        addr_valid = 1'b0;
        data_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("random_drained", 32'(q.size()), 32'd0);
        chk("random_beats", beats, m_beats);

        // Out-of-range address: truncated read plus sticky flag.
        chk("pre_oob", 32'(addr_oob), 32'd0);
        addr       = 32'h0000_0405;
        addr_valid = 1'b1;
        #1;
        chk("oob_mem_addr", 32'(mem_addr), 32'h005);
        chk("oob_mem_en", 32'(mem_en), 32'd1);
        base = got_q.size();
        step();
        addr_valid = 1'b0;
        chk("oob_set", 32'(addr_oob), 32'd1);
        send(32'd7);
        send(32'd9);
        for (int i = 0; i < 5; i++) step();
        chk("oob_sticky", 32'(addr_oob), 32'd1);
        if (got_q.size() == base + 3) begin
            chk("oob_data", got_q[base], 32'h105);
            chk("oob_data_after", got_q[base+2], 32'hA500_0009);
        end else begin
            chk("oob_beats", 32'(got_q.size() - base), 32'd3);
        end

        // Reset with two entries queued and one read in flight.
        data_ready = 1'b0;
        send(32'd1);
        send(32'd2);
        step();
        send(32'd3);
        rst_n = 1'b0;
        step();
        chk("mrst_data_valid", 32'(data_valid), 32'd0);
        chk("mrst_beats", beats, 32'd0);
        chk("mrst_oob", 32'(addr_oob), 32'd0);
        chk("mrst_addr_ready", 32'(addr_ready), 32'd1);
        rst_n      = 1'b1;
        data_ready = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 5; i++) step();
        chk("mrst_no_delivery", 32'(got_q.size() - base), 32'd0);
        chk("mrst_beats_after", beats, 32'd0);

        // Simultaneous push and pop at count 1.
        data_ready = 1'b1;
        base = got_q.size();
        for (int k = 0; k < 12; k++) begin
            addr       = 32'd32 + 32'(k);
            addr_valid = 1'b1;
            step();
            if (k >= 1 && k <= 10) chk("pp_count", 32'(dut.count), 32'd1);
        end
        addr_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pp_total", 32'(got_q.size() - base), 32'd12);
        if (got_q.size() == base + 12)
            for (int k = 0; k < 12; k++) chk("pp_data", got_q[base+k], 32'hA500_0020 + 32'(k));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
